// File: rtl/cnt_irq_ctrl.sv
// Counter-IRQ capture block: synchronizes in_port, qualifies edges through a
// hold-off window, and exposes pending/overrun status and an edge count over Avalon-MM.
module cnt_irq_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_CTRL    = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_COUNT   = 3'd3;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd4;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_OFF  = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic        s1_q, s2_q, s3_q;
  logic        ie_q, ie_d;
  logic [1:0]  edge_sel_q, edge_sel_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic [15:0] count_q, count_d;
  logic [15:0] holdoff_q, holdoff_d;
  logic [15:0] timer_q, timer_d;
  logic [0:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  logic        wr_s, wr_ctrl_s, wr_status_s, wr_count_s, wr_holdoff_s;
  logic        clr_pend_s, clr_ovr_s, cap_off_s;
  logic        rise_s, fall_s, det_s, accept_s;
  logic        unused_wdata_s;

  // Upper write-data bits have no backing storage in any register.
  assign unused_wdata_s = ^writedata[31:16];

  // Two-stage synchronizer for in_port plus the s3 history stage for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Bus write decode and edge qualification.
  always_comb begin
    wr_s         = chipselect & ~write_n;
    wr_ctrl_s    = wr_s & (address == ADDR_CTRL);
    wr_status_s  = wr_s & (address == ADDR_STATUS);
    wr_count_s   = wr_s & (address == ADDR_COUNT);
    wr_holdoff_s = wr_s & (address == ADDR_HOLDOFF);
    clr_pend_s   = wr_status_s & writedata[0];
    clr_ovr_s    = wr_status_s & writedata[1];
    cap_off_s    = wr_ctrl_s & (writedata[2:1] == EDGE_OFF);
    rise_s       = s2_q & ~s3_q;
    fall_s       = ~s2_q & s3_q;
    det_s        = 1'b0;
    case (edge_sel_q)
      EDGE_RISE: det_s = rise_s;
      EDGE_FALL: det_s = fall_s;
      EDGE_BOTH: det_s = rise_s | fall_s;
      default:   det_s = 1'b0;
    endcase
    accept_s = det_s & (state_q == ST_IDLE);
  end

  // Configuration registers (CTRL, HOLDOFF).
  always_comb begin
    ie_d       = ie_q;
    edge_sel_d = edge_sel_q;
    holdoff_d  = holdoff_q;
    if (wr_ctrl_s) begin
      ie_d       = writedata[0];
      edge_sel_d = writedata[2:1];
    end else begin
      ie_d       = ie_q;
      edge_sel_d = edge_sel_q;
    end
    if (wr_holdoff_s) begin
      holdoff_d = writedata[15:0];
    end else begin
      holdoff_d = holdoff_q;
    end
  end

  // Status and edge counter; a capture wins over a same-cycle clear.
  always_comb begin
    pend_d  = (pend_q & ~clr_pend_s) | accept_s;
    ovr_d   = (ovr_q & ~clr_ovr_s) | (accept_s & pend_q);
    count_d = count_q;
    if (accept_s) begin
      if (wr_count_s) begin
        count_d = 16'd1;
      end else if (count_q == 16'hFFFF) begin
        count_d = count_q;
      end else begin
        count_d = count_q + 16'd1;
      end
    end else if (wr_count_s) begin
      count_d = 16'd0;
    end else begin
      count_d = count_q;
    end
  end

  // Hold-off FSM: the timer snapshots HOLDOFF at capture, so later writes only affect the next window.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (cap_off_s) begin
      state_d = ST_IDLE;
      timer_d = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s && (holdoff_q != 16'd0)) begin
            state_d = ST_HOLD;
            timer_d = holdoff_q;
          end else begin
            state_d = ST_IDLE;
            timer_d = 16'd0;
          end
        end
        ST_HOLD: begin
          if (timer_q <= 16'd1) begin
            state_d = ST_IDLE;
            timer_d = 16'd0;
          end else begin
            state_d = ST_HOLD;
            timer_d = timer_q - 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = 16'd0;
        end
      endcase
    end
  end

  // Read-back mux and interrupt level, both registered.
  always_comb begin
    rdata_d = 32'h0000_0000;
    case (address)
      ADDR_DATA:    rdata_d = {31'd0, s2_q};
      ADDR_CTRL:    rdata_d = {29'd0, edge_sel_q, ie_q};
      ADDR_STATUS:  rdata_d = {30'd0, ovr_q, pend_q};
      ADDR_COUNT:   rdata_d = {16'd0, count_q};
      ADDR_HOLDOFF: rdata_d = {16'd0, holdoff_q};
      default:      rdata_d = 32'h0000_0000;
    endcase
    irq_d = pend_d & ie_d;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie_q       <= 1'b0;
      edge_sel_q <= 2'b00;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
      count_q    <= 16'd0;
      holdoff_q  <= 16'd0;
      timer_q    <= 16'd0;
      state_q    <= ST_IDLE;
      rdata_q    <= 32'h0000_0000;
      irq_q      <= 1'b0;
    end else begin
      ie_q       <= ie_d;
      edge_sel_q <= edge_sel_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      count_q    <= count_d;
      holdoff_q  <= holdoff_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_cnt_irq_ctrl.sv
// Directed self-checking bench for cnt_irq_ctrl; inputs driven and outputs sampled on falling edges.
module tb_cnt_irq_ctrl;

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_CTRL    = 3'd1;
  localparam logic [2:0] A_STATUS  = 3'd2;
  localparam logic [2:0] A_COUNT   = 3'd3;
  localparam logic [2:0] A_HOLDOFF = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        in_port;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  cnt_irq_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic do_reset();
    chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
    reset_n = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(1);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    in_port = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
    reset_n = 1'b0;
    cycles(3);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got 0x%0h expected 0x0", readdata); end
    reset_n = 1'b1;
    cycles(1);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got 0x%0h expected 0x0", a, rd); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    do_reset();
    bus_write(A_HOLDOFF, 32'hABCD_1234);
    bus_read(A_HOLDOFF, rd);
    n_checks++;
    if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL holdoff_rw: got 0x%0h expected 0x1234", rd); end
    bus_write(A_CTRL, 32'hFFFF_FFF8);
    bus_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL ctrl_upper_bits: got 0x%0h expected 0x0", rd); end
    bus_write(A_CTRL, 32'hFFFF_FFFF);
    bus_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h7) begin n_fail++; $display("FAIL ctrl_rw: got 0x%0h expected 0x7", rd); end
    // Write strobe without chipselect must be ignored.
    address = A_HOLDOFF; writedata = 32'h5555; write_n = 1'b0; chipselect = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
    bus_read(A_HOLDOFF, rd);
    n_checks++;
    if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL no_chipselect: got 0x%0h expected 0x1234", rd); end
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_write(A_DATA, 32'hFFFF_FFFF);
    for (int a = 5; a < 8; a++) begin
      bus_read(3'(a), rd);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL reserved%0d: got 0x%0h expected 0x0", a, rd); end
    end
    bus_read(A_DATA, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL data_ro: got 0x%0h expected 0x0", rd); end
  endtask

  task automatic test_basic_capture();
    logic [31:0] rd;
    in_port = 1'b0;
    do_reset();
    bus_write(A_CTRL, 32'h1);
    in_port = 1'b1;
    cycles(2);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL latency_k1_irq: got %b expected 0", irq); end
    cycles(1);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL latency_k2_irq: got %b expected 1", irq); end
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL basic_status: got 0x%0h expected 0x1", rd); end
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL basic_count: got 0x%0h expected 0x1", rd); end
    bus_read(A_DATA, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL basic_data: got 0x%0h expected 0x1", rd); end
    // Falling edge is not a capture in rising mode.
    in_port = 1'b0;
    cycles(4);
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL rising_ignores_fall: got 0x%0h expected 0x1", rd); end
  endtask

  task automatic test_both_edges_holdoff();
    logic [31:0] rd;
    in_port = 1'b0;
    do_reset();
    bus_write(A_HOLDOFF, 32'd10);
    bus_write(A_CTRL, 32'h5);
    // Nine toggles 4 cycles apart; window 10 keeps toggles 0, 3 and 6.
    for (int i = 0; i < 9; i++) begin
      in_port = ~in_port;
      cycles(4);
    end
    cycles(2);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL both_irq: got %b expected 1", irq); end
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'd3) begin n_fail++; $display("FAIL both_count: got 0x%0h expected 0x3", rd); end
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h3) begin n_fail++; $display("FAIL both_status: got 0x%0h expected 0x3", rd); end
    bus_write(A_STATUS, 32'h1);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b expected 0", irq); end
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h2) begin n_fail++; $display("FAIL w1c_ovr_kept: got 0x%0h expected 0x2", rd); end
  endtask

  task automatic test_holdoff_window();
    logic [31:0] rd;
    in_port = 1'b0;
    do_reset();
    bus_write(A_HOLDOFF, 32'd3);
    bus_write(A_CTRL, 32'h5);
    in_port = 1'b1;              // accepted at posedge a
    cycles(3);
    in_port = 1'b0;              // seen at a+3: inside window
    cycles(1);
    in_port = 1'b1;              // seen at a+4: first cycle after window
    cycles(3);
    bus_write(A_HOLDOFF, 32'd50); // during HOLD: must not touch running timer
    in_port = 1'b0;              // seen 4 cycles after previous capture
    cycles(4);
    in_port = 1'b1;              // inside new 50-cycle window
    cycles(4);
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'd3) begin n_fail++; $display("FAIL holdoff_boundary: got 0x%0h expected 0x3", rd); end
    bus_write(A_CTRL, 32'h7);
    bus_write(A_CTRL, 32'h5);
    in_port = 1'b0;
    cycles(3);
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'd4) begin n_fail++; $display("FAIL capture_off_abort: got 0x%0h expected 0x4", rd); end
  endtask

  task automatic test_no_holdoff();
    logic [31:0] rd;
    in_port = 1'b0;
    do_reset();
    bus_write(A_CTRL, 32'h1);
    in_port = 1'b1; cycles(4);
    in_port = 1'b0; cycles(4);
    in_port = 1'b1; cycles(4);
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h3) begin n_fail++; $display("FAIL nohold_status: got 0x%0h expected 0x3", rd); end
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'd2) begin n_fail++; $display("FAIL nohold_count: got 0x%0h expected 0x2", rd); end
    bus_write(A_STATUS, 32'h3);
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL status_clear_all: got 0x%0h expected 0x0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    in_port = 1'b0;
    do_reset();
    bus_write(A_CTRL, 32'h1);
    // Capture coincides with W1C PEND while PEND was 0: PEND set, no OVR.
    in_port = 1'b1; cycles(2);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL set_wins_no_ovr: got 0x%0h expected 0x1", rd); end
    in_port = 1'b0; cycles(4);
    // Same again with PEND already 1: OVR must set.
    in_port = 1'b1; cycles(2);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h3) begin n_fail++; $display("FAIL set_wins_ovr: got 0x%0h expected 0x3", rd); end
    in_port = 1'b0; cycles(4);
    in_port = 1'b1; cycles(2);
    bus_write(A_COUNT, 32'h0);
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'd1) begin n_fail++; $display("FAIL count_clear_with_edge: got 0x%0h expected 0x1", rd); end
    bus_write(A_COUNT, 32'h0);
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL count_clear: got 0x%0h expected 0x0", rd); end
  endtask

  task automatic test_saturation();
    logic [31:0] rd;
    in_port = 1'b0;
    do_reset();
    bus_write(A_CTRL, 32'h4);    // both edges, IE off
    for (int i = 0; i < 65534; i++) begin
      in_port = ~in_port;
      @(negedge clk);
    end
    cycles(3);
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'h0000_FFFE) begin n_fail++; $display("FAIL sat_pre: got 0x%0h expected 0xfffe", rd); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b expected 0", irq); end
    in_port = ~in_port; cycles(3);
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'h0000_FFFF) begin n_fail++; $display("FAIL sat_reach: got 0x%0h expected 0xffff", rd); end
    in_port = ~in_port; cycles(1);
    in_port = ~in_port; cycles(3);
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'h0000_FFFF) begin n_fail++; $display("FAIL sat_hold: got 0x%0h expected 0xffff", rd); end
  endtask

  task automatic test_reset_mid_hold();
    logic [31:0] rd;
    in_port = 1'b0;
    do_reset();
    bus_write(A_HOLDOFF, 32'd100);
    bus_write(A_CTRL, 32'h1);
    in_port = 1'b1;
    cycles(20);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL hold_irq_before_reset: got %b expected 1", irq); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL async_reset_readdata: got 0x%0h expected 0x0", readdata); end
    in_port = 1'b0;
    @(negedge clk);
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
    for (int a = 1; a < 5; a++) begin
      bus_read(3'(a), rd);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL midhold_reg%0d: got 0x%0h expected 0x0", a, rd); end
    end
    bus_write(A_CTRL, 32'h1);
    in_port = 1'b1;
    cycles(3);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL post_reset_capture: got %b expected 1", irq); end
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'd1) begin n_fail++; $display("FAIL post_reset_count: got 0x%0h expected 0x1", rd); end
  endtask

  task automatic test_high_through_reset();
    logic [31:0] rd;
    in_port = 1'b1;
    do_reset();
    cycles(2);
    bus_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL release_edge_status: got 0x%0h expected 0x1", rd); end
    bus_read(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'd1) begin n_fail++; $display("FAIL release_edge_count: got 0x%0h expected 0x1", rd); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL release_edge_irq: got %b expected 0", irq); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_basic_capture();
    test_both_edges_holdoff();
    test_holdoff_window();
    test_no_holdoff();
    test_back_to_back();
    test_reset_mid_hold();
    test_high_through_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
